id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register and load-use hazard detector between the decode stage (main control unit plus register file read) and the execute stage. Each cycle it captures the decoded control signals, register operands, immediate and PC of the instruction in ID and presents them, registered, to the ALU control, ALU, branch and memory logic in EX. It detects a load-use hazard against the instruction already in EX, stalls the front end and inserts a bubble. A taken branch resolved in EX flushes the instruction in ID.

## Interface
- XLEN, 64, datapath width (RV64, ld/sd)
- RA_W, 5, register address width
- CNT_W, 16, stall counter width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_mem_write, id_mem_read, id_mem_to_reg, id_branch, id_alu_src, id_reg_write  in  1 each  control from decode
- id_alu_op  in  2  ALUOp from decode
- id_rs1, id_rs2, id_rd  in  RA_W  register fields
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_pc  in  XLEN  instruction PC
- id_funct3  in  3  funct3 field; id_funct7_b5  in  1  instr[30]
- ex_flush  in  1  branch taken in EX, kill ID instruction
- id_stall  out  1  combinational; hold PC and IF/ID register
- ex_valid, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_branch, ex_alu_src, ex_reg_write  out  1 each
- ex_alu_op  out  2
- ex_rs1, ex_rs2, ex_rd  out  RA_W
- ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  XLEN
- ex_funct3  out  3; ex_funct7_b5  out  1
- stall_count  out  CNT_W  number of hazard stall cycles since reset

## Operation
- Hazard (combinational): hz = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (use_rs2 & ex_rd == id_rs2)); use_rs2 = ~id_alu_src | id_mem_write (R-type, beq, sd).
- id_stall = hz & ~ex_flush.
- Register update each rising edge, priority order:
  - ex_flush: load bubble.
  - id_stall: load bubble (ID instruction held upstream, re-presented next cycle).
  - else: load all id_* fields; ex_valid = id_valid; controls gated to 0 when id_valid = 0.
- Bubble: ex_valid and all control outputs (including ex_alu_op) = 0; data/field outputs load from id_* regardless (don't-care, not checked).
- stall_count increments by 1 on each edge where id_stall = 1; saturates at all-ones.
- Hazard against x0 never stalls.

## Timing
- Reset (async assert, sync-to-clk release by upstream): every registered output = 0, stall_count = 0; id_stall = 0 follows since ex_valid = 0.
- Latency: 1 cycle, ID inputs to ex_* outputs.
- Load-use costs exactly one bubble: after bubble ex_mem_read = 0, so hz clears and the held instruction passes next cycle.
- Back-to-back loads to same rd each incur one stall on their dependent consumer only.
- Flush and hazard same cycle: flush wins, id_stall = 0, stall_count unchanged.
- Reset asserted mid-stall: outputs clear immediately, no pending state retained.

## Configuration
- ID_EX_HAZARD_EN defined: hazard detection, stalling and stall_count as above.
- Not defined: hz tied 0, id_stall = 0, stall_count = 0 constant; register loads ID every cycle except flush; software must schedule load-use gaps.

## Test plan
- Reset: drive rst_n = 0 mid-cycle with valid inputs -> all ex_* = 0, stall_count = 0 immediately.
- Pass-through: R-type add x3,x1,x2 (id_alu_op = 2'b10, reg_write = 1) -> next cycle ex_alu_op = 2'b10, ex_rd = 3, ex_valid = 1.
- Load-use: ld x5,0(x1) then add x6,x5,x2 -> id_stall = 1 for one cycle, EX shows bubble, add reaches EX one cycle later, stall_count = 1.
- No false stall: ld x5 then ld x7,8(x6) with id_rs2 = 5 (unused) -> no stall; ld x0 then add x6,x0,x0 -> no stall.
- Flush priority: ex_flush = 1 while load-use hazard present -> id_stall = 0, bubble loaded, stall_count unchanged.
- Saturation: force 2^CNT_W+3 stalls -> stall_count = 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard stall and branch flush.
// Define ID_EX_HAZARD_EN to enable hazard detection, stalling and the stall counter.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_mem_write,
    input  logic             id_mem_read,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic [1:0]       id_alu_op,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7_b5,
    input  logic             ex_flush,
    output logic             id_stall,
    output logic             ex_valid,
    output logic             ex_mem_write,
    output logic             ex_mem_read,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic [1:0]       ex_alu_op,
    output logic [RA_W-1:0]  ex_rs1,
    output logic [RA_W-1:0]  ex_rs2,
    output logic [RA_W-1:0]  ex_rd,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7_b5,
    output logic [CNT_W-1:0] stall_count
);
    logic            hz;
    logic [8:0]      ctrl_d, ctrl_q;
    logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q;
    logic [2:0]      funct3_q;
    logic            funct7_b5_q;

`ifdef ID_EX_HAZARD_EN
    logic             use_rs2;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    // rs2 is only read by R-type, branches and stores
    assign use_rs2 = ~id_alu_src | id_mem_write;
    assign hz = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                ((ex_rd == id_rs1) | (use_rs2 & (ex_rd == id_rs2)));
    assign cnt_d = (id_stall & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign stall_count = cnt_q;
`else
    assign hz          = 1'b0;
    assign stall_count = '0;
`endif

    assign id_stall = hz & ~ex_flush;
    // Flush, stall and an empty ID slot all load a bubble
    assign ctrl_d = (id_valid & ~ex_flush & ~id_stall) ?
                    {1'b1, id_mem_write, id_mem_read, id_mem_to_reg, id_branch,
                     id_alu_src, id_reg_write, id_alu_op} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            funct3_q    <= '0;
            funct7_b5_q <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            pc_q        <= id_pc;
            funct3_q    <= id_funct3;
            funct7_b5_q <= id_funct7_b5;
        end
    end

    assign {ex_valid, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_branch,
            ex_alu_src, ex_reg_write, ex_alu_op} = ctrl_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_rs1_data  = rs1_data_q;
    assign ex_rs2_data  = rs2_data_q;
    assign ex_imm       = imm_q;
    assign ex_pc        = pc_q;
    assign ex_funct3    = funct3_q;
    assign ex_funct7_b5 = funct7_b5_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of the ID/EX register, hazard stall, flush and stall counter.
// Expectations follow ID_EX_HAZARD_EN so the bench suits either build.
module tb_id_ex_stage;
    localparam int XLEN  = 64;
    localparam int RA_W  = 5;
    localparam int CNT_W = 8;
`ifdef ID_EX_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif
    localparam logic [CNT_W-1:0] SAT = HZ ? {CNT_W{1'b1}} : '0;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_mem_write, id_mem_read, id_mem_to_reg, id_branch, id_alu_src, id_reg_write;
    logic [1:0] id_alu_op;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [2:0] id_funct3;
    logic id_funct7_b5, ex_flush, id_stall;
    logic ex_valid, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_branch, ex_alu_src, ex_reg_write;
    logic [1:0] ex_alu_op;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [2:0] ex_funct3;
    logic ex_funct7_b5;
    logic [CNT_W-1:0] stall_count;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_mem_write(id_mem_write),
        .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc), .id_funct3(id_funct3),
        .id_funct7_b5(id_funct7_b5), .ex_flush(ex_flush), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_funct3(ex_funct3), .ex_funct7_b5(ex_funct7_b5),
        .stall_count(stall_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, mr, mw, as, rw, input logic [1:0] op,
                         input logic [RA_W-1:0] rs1, rs2, rd);
        id_valid      = v;
        id_mem_read   = mr;
        id_mem_to_reg = mr;
        id_mem_write  = mw;
        id_alu_src    = as;
        id_reg_write  = rw;
        id_branch     = 1'b0;
        id_alu_op     = op;
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_rd         = rd;
        id_rs1_data   = 64'h1000 + XLEN'(rs1);
        id_rs2_data   = 64'h2000 + XLEN'(rs2);
        id_imm        = 64'd8;
        id_funct3     = (mr | mw) ? 3'b011 : 3'b000;
        id_funct7_b5  = 1'b0;
    endtask

    task automatic ld(input logic [RA_W-1:0] rd, rs1, rs2);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, rs1, rs2, rd);
    endtask

    task automatic add(input logic [RA_W-1:0] rd, rs1, rs2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, rs1, rs2, rd);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_flush = 1'b0;
        id_pc = '0;
        add(5'd3, 5'd1, 5'd2);
        repeat (2) @(negedge clk);
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ex_valid); else passed++;
        rst_n = 1'b1;
        cyc();
        total++; if (ex_valid !== 1'b1) $display("FAIL pre_reset_load: got %b expected 1", ex_valid); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({ex_valid, ex_reg_write, ex_alu_op} !== 4'b0) $display("FAIL reset_ctrl: got %b expected 0000", {ex_valid, ex_reg_write, ex_alu_op}); else passed++;
        total++; if (ex_rd !== '0 || ex_rs1_data !== '0) $display("FAIL reset_data: got rd=%0d rs1_data=%0h expected 0", ex_rd, ex_rs1_data); else passed++;
        total++; if (stall_count !== '0 || id_stall !== 1'b0) $display("FAIL reset_stall: got cnt=%0d stall=%b expected 0", stall_count, id_stall); else passed++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        add(5'd3, 5'd1, 5'd2);
        id_pc = 64'h100;
        cyc();
        total++; if ({ex_valid, ex_reg_write, ex_alu_op, ex_mem_read} !== 5'b11100) $display("FAIL pt_ctrl: got %b expected 11100", {ex_valid, ex_reg_write, ex_alu_op, ex_mem_read}); else passed++;
        total++; if (ex_rd !== 5'd3 || ex_rs1 !== 5'd1 || ex_rs2 !== 5'd2) $display("FAIL pt_regs: got %0d,%0d,%0d expected 3,1,2", ex_rd, ex_rs1, ex_rs2); else passed++;
        total++; if (ex_rs1_data !== 64'h1001 || ex_rs2_data !== 64'h2002 || ex_pc !== 64'h100) $display("FAIL pt_data: got %0h,%0h,%0h expected 1001,2002,100", ex_rs1_data, ex_rs2_data, ex_pc); else passed++;
        ld(5'd9, 5'd1, 5'd0);
        id_valid = 1'b0;
        cyc();
        total++; if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000) $display("FAIL pt_gate: got %b expected 000", {ex_valid, ex_mem_read, ex_reg_write}); else passed++;
    endtask

    task automatic test_load_use();
        ld(5'd5, 5'd1, 5'd0);
        cyc();
        add(5'd6, 5'd5, 5'd2);
        #1;
        total++; if (id_stall !== HZ) $display("FAIL lu_stall: got %b expected %b", id_stall, HZ); else passed++;
        cyc();
        total++; if (ex_valid !== !HZ || ex_reg_write !== !HZ) $display("FAIL lu_bubble: got valid=%b rw=%b expected %b", ex_valid, ex_reg_write, !HZ); else passed++;
        total++; if (stall_count !== CNT_W'(HZ)) $display("FAIL lu_count: got %0d expected %0d", stall_count, HZ); else passed++;
        total++; if (id_stall !== 1'b0) $display("FAIL lu_release: got %b expected 0", id_stall); else passed++;
        cyc();
        total++; if ({ex_valid, ex_alu_op} !== 3'b110 || ex_rd !== 5'd6) $display("FAIL lu_pass: got %b rd=%0d expected 110 rd=6", {ex_valid, ex_alu_op}, ex_rd); else passed++;
    endtask

    task automatic test_no_false_stall();
        ld(5'd5, 5'd1, 5'd0);
        cyc();
        ld(5'd7, 5'd6, 5'd5);
        #1;
        total++; if (id_stall !== 1'b0) $display("FAIL nfs_rs2_unused: got %b expected 0", id_stall); else passed++;
        cyc();
        total++; if ({ex_valid, ex_mem_read} !== 2'b11 || ex_rd !== 5'd7) $display("FAIL nfs_ld_pass: got %b rd=%0d expected 11 rd=7", {ex_valid, ex_mem_read}, ex_rd); else passed++;
        ld(5'd0, 5'd1, 5'd0);
        cyc();
        add(5'd6, 5'd0, 5'd0);
        #1;
        total++; if (id_stall !== 1'b0) $display("FAIL nfs_x0: got %b expected 0", id_stall); else passed++;
        cyc();
        total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) $display("FAIL nfs_x0_pass: got %b rd=%0d expected 1 rd=6", ex_valid, ex_rd); else passed++;
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] cnt;
        ld(5'd5, 5'd1, 5'd0);
        cyc();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 5'd1, 5'd5, 5'd0);
        #1;
        total++; if (id_stall !== HZ) $display("FAIL sd_rs2_stall: got %b expected %b", id_stall, HZ); else passed++;
        cnt = stall_count;
        ex_flush = 1'b1;
        #1;
        total++; if (id_stall !== 1'b0) $display("FAIL fl_stall: got %b expected 0", id_stall); else passed++;
        cyc();
        ex_flush = 1'b0;
        total++; if ({ex_valid, ex_mem_write, ex_alu_src} !== 3'b000) $display("FAIL fl_bubble: got %b expected 000", {ex_valid, ex_mem_write, ex_alu_src}); else passed++;
        total++; if (stall_count !== cnt) $display("FAIL fl_count: got %0d expected %0d", stall_count, cnt); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        ld(5'd5, 5'd1, 5'd0);
        cyc();
        add(5'd6, 5'd5, 5'd2);
        #1;
        total++; if (id_stall !== HZ) $display("FAIL rms_stall: got %b expected %b", id_stall, HZ); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if ({ex_valid, ex_mem_read, id_stall} !== 3'b000 || stall_count !== '0) $display("FAIL rms_clear: got %b cnt=%0d expected 000 cnt=0", {ex_valid, ex_mem_read, id_stall}, stall_count); else passed++;
        @(negedge clk) rst_n = 1'b1;
        cyc();
        total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) $display("FAIL rms_resume: got %b rd=%0d expected 1 rd=6", ex_valid, ex_rd); else passed++;
    endtask

    task automatic test_saturation();
        ld(5'd5, 5'd5, 5'd0);
        // Alternating stall/pass: 2k+1 edges give k stalls
        repeat (2 * ((1 << CNT_W) + 3) + 1) cyc();
        total++; if (stall_count !== SAT) $display("FAIL sat_count: got %0h expected %0h", stall_count, SAT); else passed++;
        cyc();
        total++; if (stall_count !== SAT) $display("FAIL sat_hold: got %0h expected %0h", stall_count, SAT); else passed++;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_stall();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
